// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared state, opcode and immediate-decode definitions for multicycle_core
package mc_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [31:0] ECALL = 32'h0000_0073;

    // Full 32-bit sign-extended immediate; the branch offset needs more than XLEN bits.
    function automatic logic [31:0] imm_decode(input logic [31:0] ir);
        case (ir[6:0])
            OP_STORE:  imm_decode = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OP_BRANCH: imm_decode = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            default:   imm_decode = {{20{ir[31]}}, ir[31:20]};
        endcase
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// rtl/mc_regfile.sv - REG_N x XLEN register file, two async reads, one sync write, x0 reads zero
module mc_regfile
    import mc_pkg::*;
#(
    parameter int XLEN   = 8,
    parameter int REG_N  = 32,
    parameter int RIDX_W = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RIDX_W-1:0] raddr1,
    input  logic [RIDX_W-1:0] raddr2,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2,
    input  logic              we,
    input  logic [RIDX_W-1:0] waddr,
    input  logic [XLEN-1:0]   wdata
);

    logic [XLEN-1:0] regs [REG_N];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_N; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/multicycle_core.sv
// rtl/multicycle_core.sv - multicycle RV32I-subset core; MC_BRANCH_EN enables BEQ/BNE
module multicycle_core
    import mc_pkg::*;
#(
    parameter int XLEN    = 8,
    parameter int PC_W    = 5,
    parameter int DADDR_W = 5,
    parameter int REG_N   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]    dmem_wdata,
    input  logic [XLEN-1:0]    dmem_rdata,
    input  logic               dmem_ready,
    output logic               halted
);

    localparam int RIDX_W = $clog2(REG_N);

    logic [2:0]         state;
    logic [PC_W-1:0]    pc;
    logic [31:0]        ir;
    logic [31:0]        imm_q;
    logic [XLEN-1:0]    a_q, b_q, result_q;
    logic [DADDR_W-1:0] addr_q;
    logic               we_q;
    logic [XLEN-1:0]    rs1_data, rs2_data;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    // Register indices alias mod REG_N by taking the low bits of the fields.
    mc_regfile #(.XLEN(XLEN), .REG_N(REG_N), .RIDX_W(RIDX_W)) u_rf (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (ir[15 +: RIDX_W]),
        .raddr2 (ir[20 +: RIDX_W]),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data),
        .we     (state == ST_WB),
        .waddr  (ir[7 +: RIDX_W]),
        .wdata  (result_q)
    );

    logic [XLEN-1:0] alu_b, alu_res;
    logic            alu_op, mem_op, br_op, br_taken;

    always_comb begin
        alu_op   = 1'b0;
        alu_res  = '0;
        mem_op   = 1'b0;
        br_op    = 1'b0;
        br_taken = 1'b0;
        alu_b    = (opcode == OP_R) ? b_q : imm_q[XLEN-1:0];
        case (opcode)
            OP_R: begin
                if (funct7 == F7_BASE) begin
                    alu_op = 1'b1;
                    case (funct3)
                        F3_ADD:  alu_res = a_q + alu_b;
                        F3_XOR:  alu_res = a_q ^ alu_b;
                        F3_OR:   alu_res = a_q | alu_b;
                        F3_AND:  alu_res = a_q & alu_b;
                        default: alu_op  = 1'b0;
                    endcase
                end else if (funct7 == F7_SUB && funct3 == F3_ADD) begin
                    alu_op  = 1'b1;
                    alu_res = a_q - alu_b;
                end
            end
            OP_IMM: begin
                alu_op = 1'b1;
                case (funct3)
                    F3_ADD:  alu_res = a_q + alu_b;
                    F3_OR:   alu_res = a_q | alu_b;
                    F3_AND:  alu_res = a_q & alu_b;
                    default: alu_op  = 1'b0;
                endcase
            end
            OP_LOAD, OP_STORE: mem_op = (funct3 == F3_W);
`ifdef MC_BRANCH_EN
            OP_BRANCH: begin
                br_op    = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
                br_taken = (funct3 == F3_BEQ) ? (a_q == b_q) : (a_q != b_q);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_FETCH;
            pc       <= '0;
            ir       <= '0;
            imm_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    ir    <= imem_rdata;
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    a_q   <= rs1_data;
                    b_q   <= rs2_data;
                    imm_q <= imm_decode(ir);
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (alu_op) begin
                        result_q <= alu_res;
                        state    <= ST_WB;
                    end else if (mem_op) begin
                        addr_q <= DADDR_W'(32'(a_q) + imm_q);
                        we_q   <= (opcode == OP_STORE);
                        state  <= ST_MEM;
                    end else if (br_op) begin
                        pc    <= br_taken ? pc + PC_W'($signed(imm_q) >>> 2) : pc + 1'b1;
                        state <= ST_FETCH;
                    end else begin
                        state <= ST_HALT;
                    end
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        we_q <= 1'b0;
                        if (we_q) begin
                            pc    <= pc + 1'b1;
                            state <= ST_FETCH;
                        end else begin
                            result_q <= dmem_rdata;
                            state    <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    pc    <= pc + 1'b1;
                    state <= ST_FETCH;
                end
                default: state <= ST_HALT;
            endcase
        end
    end

    assign imem_addr  = pc;
    assign dmem_req   = (state == ST_MEM);
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = b_q;
    assign halted     = (state == ST_HALT);

endmodule

// File: tb/tb_multicycle_core.sv
// tb/tb_multicycle_core.sv - self-checking bench for multicycle_core (honours MC_BRANCH_EN)
module tb_multicycle_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        dmem_req, dmem_we, dmem_ready, halted;
    logic [4:0]  dmem_addr;
    logic [7:0]  dmem_wdata;
    logic [7:0]  dmem_rdata = 8'hA5;

    logic [31:0] rom [32];
    assign imem_rdata = rom[imem_addr];

    multicycle_core #(.XLEN(8), .PC_W(5), .DADDR_W(5), .REG_N(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] enc_i(int imm, int rs1, logic [2:0] f3, int rd, logic [6:0] opc);
        logic [11:0] im;
        im = 12'(imm);
        return {im, 5'(rs1), f3, 5'(rd), opc};
    endfunction

    function automatic logic [31:0] enc_r(logic [6:0] f7, int rs2, int rs1, logic [2:0] f3, int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
        logic [11:0] im;
        im = 12'(imm);
        return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, logic [2:0] f3);
        logic [12:0] im;
        im = 13'(imm);
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), f3, im[4:1], im[11], 7'b1100011};
    endfunction

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ECL  = 32'h0000_0073;

    // Data memory model and scoreboard of expected accesses.
    typedef struct {
        logic       we;
        logic [4:0] addr;
        logic [7:0] data;
    } txn_t;
    txn_t sb[$];

    int         wait_cfg = 0;
    int         wcnt = 0;
    int         req_cycles = 0;
    int         last_req_cycles = 0;
    int         total_req = 0;
    int         txn_no = 0;
    logic       stable;
    logic       cap_we;
    logic [4:0] cap_addr;
    logic [7:0] cap_wdata;

    initial dmem_ready = 1'b0;

    always @(negedge clk) begin
        if (dmem_req) total_req++;
        if (rst_n && dmem_req) begin
            if (req_cycles == 0) begin
                cap_we = dmem_we; cap_addr = dmem_addr; cap_wdata = dmem_wdata; stable = 1'b1;
            end else if (dmem_we !== cap_we || dmem_addr !== cap_addr || dmem_wdata !== cap_wdata) begin
                stable = 1'b0;
            end
            req_cycles++;
            if (wcnt >= wait_cfg) begin
                txn_t e;
                dmem_ready = 1'b1;
                last_req_cycles = req_cycles;
                txn_no++;
                if (sb.size() == 0) begin
                    check($sformatf("txn%0d_unexpected", txn_no), {dmem_we, dmem_addr, dmem_wdata}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("txn%0d_stable", txn_no), {31'd0, stable}, 32'd1);
                    check($sformatf("txn%0d we/addr/data", txn_no),
                          {dmem_we, dmem_addr, dmem_we ? dmem_wdata : 8'h00},
                          {e.we, e.addr, e.we ? e.data : 8'h00});
                end
                wcnt = 0;
                req_cycles = 0;
            end else begin
                dmem_ready = 1'b0;
                wcnt++;
            end
        end else begin
            dmem_ready = 1'b0;
            wcnt = 0;
            req_cycles = 0;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(output int lat);
        logic [4:0] p0;
        p0  = imem_addr;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (imem_addr == p0 && !halted && lat < 200);
        if (lat >= 200) begin
            n_checks++;
            $display("FAIL step_timeout: pc stuck at %0d", p0);
        end
    endtask

    task automatic wait_halt(input string name);
        int c;
        c = 0;
        while (!halted && c < 300) begin
            @(negedge clk);
            c++;
        end
        check(name, {31'd0, halted}, 32'd1);
    endtask

    typedef struct {
        string      name;
        logic [31:0] instr;
        int         a;
        int         b;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[9];

    initial begin
        int lat;
        int snap;

        vecs[0] = '{"ADD",    enc_r(7'h00, 2, 1, 3'b000, 3), 5,    -3,   8'h02};
        vecs[1] = '{"SUB",    enc_r(7'h20, 2, 1, 3'b000, 3), 5,    7,    8'hFE};
        vecs[2] = '{"AND",    enc_r(7'h00, 2, 1, 3'b111, 3), 'h5A, 'h0F, 8'h0A};
        vecs[3] = '{"OR",     enc_r(7'h00, 2, 1, 3'b110, 3), 'h50, 'h0F, 8'h5F};
        vecs[4] = '{"XOR",    enc_r(7'h00, 2, 1, 3'b100, 3), 'h55, 'h7F, 8'h2A};
        vecs[5] = '{"ADDwrap",enc_r(7'h00, 2, 1, 3'b000, 3), -128, -1,   8'h7F};
        vecs[6] = '{"ADDI",   enc_i(-20,  1, 3'b000, 3, 7'b0010011), 10,   'h77, 8'hF6};
        vecs[7] = '{"ANDI",   enc_i(-16,  1, 3'b111, 3, 7'b0010011), 'hC3, 'h77, 8'hC0};
        vecs[8] = '{"ORI",    enc_i('h21, 1, 3'b110, 3, 7'b0010011), 'h12, 'h77, 8'h33};

        for (int i = 0; i < 32; i++) rom[i] = NOP;

        // Reset state, observed while reset is still asserted.
        repeat (2) @(negedge clk);
        check("rst_pc", {27'd0, imem_addr}, 32'd0);
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_we", {31'd0, dmem_we}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);

        // Table-driven ALU vectors: result observed through a following store.
        for (int v = 0; v < 9; v++) begin
            for (int i = 0; i < 32; i++) rom[i] = NOP;
            rom[0] = enc_i(vecs[v].a, 0, 3'b000, 1, 7'b0010011);
            rom[1] = enc_i(vecs[v].b, 0, 3'b000, 2, 7'b0010011);
            rom[2] = vecs[v].instr;
            rom[3] = enc_s(v + 8, 3, 0);
            rom[4] = ECL;
            wait_cfg = 0;
            sb.push_back('{1'b1, 5'(v + 8), vecs[v].exp});
            do_reset();
            wait_halt({vecs[v].name, "_halt"});
            check({vecs[v].name, "_sb_drained"}, sb.size(), 32'd0);
            sb.delete();
        end

        // Main program: latencies, wait states, load, x0 write, ECALL.
        for (int i = 0; i < 32; i++) rom[i] = NOP;
        rom[0] = enc_i(5, 0, 3'b000, 1, 7'b0010011);
        rom[1] = enc_i(-3, 0, 3'b000, 2, 7'b0010011);
        rom[2] = enc_r(7'h00, 2, 1, 3'b000, 3);
        rom[3] = enc_s(4, 3, 0);
        rom[4] = enc_i(4, 0, 3'b010, 4, 7'b0000011);
        rom[5] = enc_i(4, 0, 3'b010, 0, 7'b0000011);
        rom[6] = enc_s(5, 4, 0);
        rom[7] = enc_s(6, 0, 0);
        rom[8] = ECL;
        sb.push_back('{1'b1, 5'd4, 8'h02});
        sb.push_back('{1'b0, 5'd4, 8'h00});
        sb.push_back('{1'b0, 5'd4, 8'h00});
        sb.push_back('{1'b1, 5'd5, 8'hA5});
        sb.push_back('{1'b1, 5'd6, 8'h00});
        dmem_rdata = 8'hA5;
        wait_cfg = 0;
        do_reset();
        step(lat); check("lat_addi1", lat, 32'd4);
        step(lat); check("lat_addi2", lat, 32'd4);
        step(lat); check("lat_add", lat, 32'd4);
        wait_cfg = 3;
        step(lat); check("lat_sw_w3", lat, 32'd7);
        check("sw_req_cycles", last_req_cycles, 32'd4);
        wait_cfg = 2;
        step(lat); check("lat_lw_w2", lat, 32'd7);
        wait_cfg = 0;
        step(lat); check("lat_lw_x0", lat, 32'd5);
        step(lat); check("lat_sw_x4", lat, 32'd4);
        step(lat); check("lat_sw_x0", lat, 32'd4);
        step(lat); check("lat_ecall", lat, 32'd3);
        check("ecall_halted", {31'd0, halted}, 32'd1);
        snap = total_req;
        repeat (20) @(negedge clk);
        check("halt_no_req", total_req - snap, 32'd0);
        check("halt_pc_frozen", {27'd0, imem_addr}, 32'd8);
        check("main_sb_drained", sb.size(), 32'd0);
        sb.delete();

        // Branch at PC=6 back to PC=4.
        for (int i = 0; i < 32; i++) rom[i] = NOP;
        rom[0] = enc_i(1, 0, 3'b000, 1, 7'b0010011);
        rom[6] = enc_b(-8, 1, 1, 3'b000);
        do_reset();
        for (int i = 0; i < 6; i++) step(lat);
        check("br_at_pc6", {27'd0, imem_addr}, 32'd6);
        step(lat);
        check("br_lat", lat, 32'd3);
`ifdef MC_BRANCH_EN
        check("br_target", {27'd0, imem_addr}, 32'd4);
        check("br_not_halted", {31'd0, halted}, 32'd0);
`else
        check("br_illegal_halt", {31'd0, halted}, 32'd1);
        check("br_pc_held", {27'd0, imem_addr}, 32'd6);
`endif

        // PC wraps from 31 to 0.
        for (int i = 0; i < 32; i++) rom[i] = NOP;
        do_reset();
        for (int i = 0; i < 31; i++) step(lat);
        check("wrap_at_31", {27'd0, imem_addr}, 32'd31);
        step(lat);
        check("wrap_lat", lat, 32'd4);
        check("wrap_pc0", {27'd0, imem_addr}, 32'd0);

        // Reset while a store is waiting for ready.
        rom[0] = enc_s(3, 0, 0);
        wait_cfg = 1000;
        do_reset();
        snap = 0;
        while (!dmem_req && snap < 10) begin
            @(negedge clk);
            snap++;
        end
        check("midmem_req_seen", {31'd0, dmem_req}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midmem_req_low", {31'd0, dmem_req}, 32'd0);
        check("midmem_pc", {27'd0, imem_addr}, 32'd0);
        check("midmem_halted", {31'd0, halted}, 32'd0);
        check("midmem_state", {29'd0, dut.state}, {29'd0, mc_pkg::ST_FETCH});
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
